// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - request/response bundle between decode, alu_seq and writeback
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, zero, overflow, carry, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result_lo, result_hi, zero, overflow, carry, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with single-cycle ops and iterative shift-add multiply
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_SLT  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;

  typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

  state_t state, state_next;

  logic               ready;
  logic               accept;
  logic               is_mul;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [WIDTH-1:0]   alu_lo;
  logic               alu_ovf;
  logic               alu_carry;
  logic               alu_ill;
  logic               alu_zero;

  // Multiplicand shifts left and multiplier shifts right each iteration, so
  // mplier[0] is always bit[counter] and mcand is always a<<counter.
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt;
  logic               mul_last;

  logic [WIDTH-1:0]   res_lo;
  logic [WIDTH-1:0]   res_hi;
  logic               res_zero;
  logic               res_ovf;
  logic               res_carry;
  logic               res_ill;

  assign is_mul = (bus.op == OP_MUL);

  // Single-cycle operations computed straight from the presented operands.
  // SLT uses sign(a-b) xor overflow so it stays correct when a-b overflows;
  // SLTU is the borrow out of a+~b+1.
  always_comb begin
    sum       = {1'b0, bus.a} + {1'b0, bus.b};
    diff      = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    add_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    sub_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
    alu_lo    = '0;
    alu_ovf   = 1'b0;
    alu_carry = 1'b0;
    alu_ill   = 1'b0;
    case (bus.op)
      OP_ADD: begin
        alu_lo    = sum[WIDTH-1:0];
        alu_ovf   = add_ovf;
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_lo    = diff[WIDTH-1:0];
        alu_ovf   = sub_ovf;
        alu_carry = diff[WIDTH];
      end
      OP_XOR:  alu_lo = bus.a ^ bus.b;
      OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
      OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, ~diff[WIDTH]};
      OP_MUL:  alu_lo = '0;
      default: alu_ill = 1'b1;
    endcase
    alu_zero = !alu_ill && (alu_lo == '0);
  end

  // One shift-add iteration of the multiplier.
  always_comb begin
    acc_step = mplier[0] ? (acc + mcand) : acc;
    mul_last = (cnt == CW'(WIDTH - 1));
  end

  // Handshake and next-state logic.
  always_comb begin
    ready      = (state == IDLE) || ((state == DONE) && bus.out_ready);
    accept     = bus.in_valid && ready;
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = is_mul ? MUL_BUSY : DONE;
        end else if ((state == DONE) && bus.out_ready) begin
          state_next = IDLE;
        end
      end
      MUL_BUSY: begin
        if (mul_last) begin
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, multiply iterations and registered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      res_lo    <= '0;
      res_hi    <= '0;
      res_zero  <= 1'b0;
      res_ovf   <= 1'b0;
      res_carry <= 1'b0;
      res_ill   <= 1'b0;
    end else if (accept) begin
      if (is_mul) begin
        mcand  <= {{WIDTH{1'b0}}, bus.a};
        mplier <= bus.b;
        acc    <= '0;
        cnt    <= '0;
      end else begin
        res_lo    <= alu_lo;
        res_hi    <= '0;
        res_zero  <= alu_zero;
        res_ovf   <= alu_ovf;
        res_carry <= alu_carry;
        res_ill   <= alu_ill;
      end
    end else if (state == MUL_BUSY) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (mul_last) begin
        res_lo    <= acc_step[WIDTH-1:0];
        res_hi    <= acc_step[2*WIDTH-1:WIDTH];
        res_zero  <= (acc_step[WIDTH-1:0] == '0);
        res_ovf   <= |acc_step[2*WIDTH-1:WIDTH];
        res_carry <= 1'b0;
        res_ill   <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out_valid = (state == DONE);
  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;
  assign bus.zero      = res_zero;
  assign bus.overflow  = res_ovf;
  assign bus.carry     = res_carry;
  assign bus.illegal   = res_ill;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed bench for alu_seq against an arithmetic reference model
module tb_alu_seq;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq_if #(.WIDTH(8))  bus8 ();

  alu_seq #(.WIDTH(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        ovf;
    logic        carry;
    logic        ill;
  } obs_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    obs_t        exp;
    logic [7:0]  lat;
  } dvec_t;

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic obs_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    obs_t        r;
    longint      sa;
    longint      sb;
    longint      s;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: begin
        s       = sa + sb;
        r.lo    = a + b;
        r.ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.carry = (ua + ub) > 64'hFFFF_FFFF;
      end
      3'd1: begin
        s       = sa - sb;
        r.lo    = a - b;
        r.ovf   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        r.carry = (a >= b);
      end
      3'd2: r.lo = a ^ b;
      3'd3: r.lo = (sa < sb) ? 32'd1 : 32'd0;
      3'd5: r.lo = (a < b) ? 32'd1 : 32'd0;
      3'd4: begin
        p     = ua * ub;
        r.lo  = p[31:0];
        r.hi  = p[63:32];
        r.ovf = (p[63:32] != 32'd0);
      end
      default: r.ill = 1'b1;
    endcase
    r.zero = !r.ill && (r.lo == 32'd0);
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.lo    = bus.result_lo;
    o.hi    = bus.result_hi;
    o.zero  = bus.zero;
    o.ovf   = bus.overflow;
    o.carry = bus.carry;
    o.ill   = bus.illegal;
    return o;
  endfunction

  // Runs one transaction on the 32-bit unit: present, accept, wait for result, consume.
  task automatic exec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output obs_t o, output int lat);
    int n;
    @(negedge clk);
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 3'($urandom);
    bus.a        = $urandom;
    bus.b        = $urandom;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    o = sample();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_handshake out_valid=%b in_ready=%b required out_valid=0 in_ready=1", bus.out_valid, bus.in_ready);
    end
    checks++;
    if (sample() !== obs_t'(0)) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=0", sample());
    end
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.result_lo !== 8'd0 || bus8.result_hi !== 8'd0) begin
      failures++;
      $display("FAIL reset_w8 out_valid=%b lo=%h hi=%h required 0/00/00", bus8.out_valid, bus8.result_lo, bus8.result_hi);
    end
  endtask

  task automatic test_directed();
    dvec_t dv[11];
    obs_t  o;
    int    lat;
    dv = '{
      '{3'd0, 32'd2,          32'd5,          '{32'd7,          32'd0,          1'b0, 1'b0, 1'b0, 1'b0}, 8'd1},
      '{3'd1, 32'd5,          32'd7,          '{32'hFFFF_FFFE,  32'd0,          1'b0, 1'b0, 1'b0, 1'b0}, 8'd1},
      '{3'd1, 32'd7,          32'd7,          '{32'd0,          32'd0,          1'b1, 1'b0, 1'b1, 1'b0}, 8'd1},
      '{3'd0, 32'h7FFF_FFFF,  32'd1,          '{32'h8000_0000,  32'd0,          1'b0, 1'b1, 1'b0, 1'b0}, 8'd1},
      '{3'd3, 32'h8000_0000,  32'd1,          '{32'd1,          32'd0,          1'b0, 1'b0, 1'b0, 1'b0}, 8'd1},
      '{3'd5, 32'h8000_0000,  32'd1,          '{32'd0,          32'd0,          1'b1, 1'b0, 1'b0, 1'b0}, 8'd1},
      '{3'd2, 32'h0000_F0F0,  32'h0000_0FF0,  '{32'h0000_FF00,  32'd0,          1'b0, 1'b0, 1'b0, 1'b0}, 8'd1},
      '{3'd4, 32'd2,          32'd5,          '{32'd10,         32'd0,          1'b0, 1'b0, 1'b0, 1'b0}, 8'd33},
      '{3'd4, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  '{32'd1,          32'hFFFF_FFFE,  1'b0, 1'b1, 1'b0, 1'b0}, 8'd33},
      '{3'd6, 32'd5,          32'd3,          '{32'd0,          32'd0,          1'b0, 1'b0, 1'b0, 1'b1}, 8'd1},
      '{3'd7, 32'hFFFF_FFFF,  32'd1,          '{32'd0,          32'd0,          1'b0, 1'b0, 1'b0, 1'b1}, 8'd1}
    };
    for (int i = 0; i < 11; i++) begin
      exec(dv[i].op, dv[i].a, dv[i].b, o, lat);
      checks++;
      if (o !== dv[i].exp) begin
        failures++;
        $display("FAIL directed_%0d op=%0d got=%h required=%h", i, dv[i].op, o, dv[i].exp);
      end
      checks++;
      if (lat != int'(dv[i].lat)) begin
        failures++;
        $display("FAIL directed_lat_%0d op=%0d got=%0d required=%0d", i, dv[i].op, lat, dv[i].lat);
      end
    end
  endtask

  task automatic test_random();
    obs_t        o;
    obs_t        e;
    int          lat;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] corner[4];
    corner = '{32'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
      exec(op, a, b, o, lat);
      e = model(op, a, b);
      checks++;
      if (o !== e || lat != ((op == 3'd4) ? 33 : 1)) begin
        failures++;
        $display("FAIL random_%0d op=%0d a=%h b=%h got=%h lat=%0d required=%h", i, op, a, b, o, lat, e);
      end
    end
  endtask

  task automatic test_mul_stall();
    logic [31:0] a;
    logic [31:0] b;
    int          busy_ready;
    int          lat;
    obs_t        e;
    a = $urandom;
    b = $urandom;
    e = model(3'd4, a, b);
    @(negedge clk);
    bus.op = 3'd4; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    busy_ready = 0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      bus.op = 3'($urandom_range(0, 5));
      bus.a  = $urandom;
      bus.b  = $urandom;
      if (bus.in_ready) busy_ready++;
      @(negedge clk);
      lat++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (busy_ready != 0 || lat != 33) begin
      failures++;
      $display("FAIL mul_stall in_ready_cycles=%0d lat=%0d required 0 and 33", busy_ready, lat);
    end
    checks++;
    if (sample() !== e) begin
      failures++;
      $display("FAIL mul_stall_result got=%h required=%h", sample(), e);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    obs_t        snap;
    obs_t        e;
    logic [31:0] ba[4];
    logic [31:0] bb[4];
    logic [31:0] a0;
    logic [31:0] b0;
    a0 = $urandom;
    b0 = $urandom;
    for (int k = 0; k < 4; k++) begin
      ba[k] = $urandom;
      bb[k] = $urandom;
    end
    @(negedge clk);
    bus.op = 3'd0; bus.a = a0; bus.b = b0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    snap = sample();
    checks++;
    if (bus.out_valid !== 1'b1 || snap !== model(3'd0, a0, b0)) begin
      failures++;
      $display("FAIL bp_first out_valid=%b got=%h required=%h", bus.out_valid, snap, model(3'd0, a0, b0));
    end
    for (int c = 0; c < 10; c++) begin
      bus.op = 3'($urandom_range(0, 5));
      bus.a  = $urandom;
      bus.b  = $urandom;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || sample() !== snap) begin
        failures++;
        $display("FAIL bp_hold_%0d out_valid=%b in_ready=%b got=%h required=%h", c, bus.out_valid, bus.in_ready, sample(), snap);
      end
    end
    bus.out_ready = 1'b1;
    bus.op = 3'd0; bus.a = ba[0]; bus.b = bb[0];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = model(3'd0, ba[k], bb[k]);
      checks++;
      if (bus.out_valid !== 1'b1 || sample() !== e) begin
        failures++;
        $display("FAIL b2b_%0d out_valid=%b got=%h required=%h", k, bus.out_valid, sample(), e);
      end
      if (k < 3) begin
        bus.a = ba[k+1];
        bus.b = bb[k+1];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_drain out_valid=%b in_ready=%b required 0 and 1", bus.out_valid, bus.in_ready);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_mul();
    obs_t o;
    int   lat;
    exec(3'd0, 32'd2, 32'd5, o, lat);
    @(negedge clk);
    bus.op = 3'd4; bus.a = 32'd3; bus.b = 32'd5; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result_lo !== 32'd0 || bus.result_hi !== 32'd0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_mul_reset out_valid=%b lo=%h hi=%h in_ready=%b required 0/0/0/1",
               bus.out_valid, bus.result_lo, bus.result_hi, bus.in_ready);
    end
    reset = 1'b0;
    repeat (40) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_mul_discard out_valid=%b required=0", bus.out_valid);
    end
    exec(3'd1, 32'd9, 32'd4, o, lat);
    checks++;
    if (o !== model(3'd1, 32'd9, 32'd4) || lat != 1) begin
      failures++;
      $display("FAIL mid_mul_recover got=%h lat=%0d required=%h lat=1", o, lat, model(3'd1, 32'd9, 32'd4));
    end
  endtask

  task automatic test_width8();
    logic [2:0] ops[2];
    logic [7:0] as[2];
    logic [7:0] bs[2];
    logic [7:0] elo[2];
    logic [7:0] ehi[2];
    logic [3:0] efl[2];
    int         elat[2];
    int         lat;
    ops = '{3'd4, 3'd0};   as  = '{8'hFF, 8'h7F}; bs = '{8'hFF, 8'h01};
    elo = '{8'h01, 8'h80}; ehi = '{8'hFE, 8'h00};
    efl = '{4'b0100, 4'b0100};
    elat = '{9, 1};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus8.op = ops[i]; bus8.a = as[i]; bus8.b = bs[i]; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
      @(negedge clk);
      bus8.in_valid = 1'b0;
      lat = 1;
      while (!bus8.out_valid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (bus8.result_lo !== elo[i] || bus8.result_hi !== ehi[i] || lat != elat[i] ||
          {bus8.zero, bus8.overflow, bus8.carry, bus8.illegal} !== efl[i]) begin
        failures++;
        $display("FAIL w8_%0d lo=%h hi=%h flags=%b lat=%0d required lo=%h hi=%h flags=%b lat=%0d", i,
                 bus8.result_lo, bus8.result_hi, {bus8.zero, bus8.overflow, bus8.carry, bus8.illegal}, lat,
                 elo[i], ehi[i], efl[i], elat[i]);
      end
      bus8.out_ready = 1'b1;
      @(negedge clk);
      bus8.out_ready = 1'b0;
    end
  endtask

  // Test sequence.
  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    bus8.op        = 3'd0;
    bus8.a         = '0;
    bus8.b         = '0;
    test_reset();
    test_directed();
    test_random();
    test_mul_stall();
    test_backpressure();
    test_reset_mid_mul();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
